// File: rtl/dual_core_mem_arbiter.sv
// dual_core_mem_arbiter: round-robin arbiter of two CPU cores onto one synchronous memory port.
// Optional MEM_TIMEOUT_EN adds a MEM-state watchdog and a sticky bus_err output.
module dual_core_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [DATA_W-1:0] Sysbus,
    input  logic              nALE,
    input  logic              nME,
    input  logic              RnW,
    output logic [DATA_W-1:0] Data_in,
    output logic              Ready,
    input  logic [DATA_W-1:0] Sysbus2,
    input  logic              nALE2,
    input  logic              nME2,
    input  logic              RnW2,
    output logic [DATA_W-1:0] Data_in2,
    output logic              Ready2,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
`ifdef MEM_TIMEOUT_EN
    output logic              bus_err,
`endif
    output logic              grant
);
    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
    state_t state, state_d;
    logic pend0, pend1, nme_q, nme2_q, last_grant, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1, rdata_eff;
    logic win, start, done, tmo_hit;

    assign win       = (pend0 && pend1) ? ~last_grant : pend1;
    assign start     = state == IDLE && (pend0 || pend1);
    assign done      = state == MEM && (mem_ack || tmo_hit);
    assign rdata_eff = mem_ack ? mem_rdata : '1;
    assign Ready     = state == RESP && !grant;
    assign Ready2    = state == RESP && grant;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;
    assign tmo_hit = state == MEM && !mem_ack && tmo_cnt == CW'(TIMEOUT - 1);
    // Watchdog counts MEM cycles from zero on entry; a hit latches bus_err until reset
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            tmo_cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            tmo_cnt <= state == MEM ? tmo_cnt + 1'b1 : '0;
            if (tmo_hit) bus_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Per-port front end: latch address, capture one request per sampled nME falling edge
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            nme_q  <= 1'b1;
            nme2_q <= 1'b1;
            pend0  <= 1'b0;
            pend1  <= 1'b0;
            we0    <= 1'b0;
            we1    <= 1'b0;
            addr0  <= '0;
            addr1  <= '0;
            wdata0 <= '0;
            wdata1 <= '0;
        end else begin
            nme_q  <= nME;
            nme2_q <= nME2;
            if (!nALE && !pend0) addr0 <= Sysbus[ADDR_W-1:0];
            if (!nALE2 && !pend1) addr1 <= Sysbus2[ADDR_W-1:0];
            if (!nME && nme_q && !pend0) begin
                pend0  <= 1'b1;
                we0    <= ~RnW;
                wdata0 <= Sysbus;
            end else if (state == RESP && !grant) begin
                pend0 <= 1'b0;
            end
            if (!nME2 && nme2_q && !pend1) begin
                pend1  <= 1'b1;
                we1    <= ~RnW2;
                wdata1 <= Sysbus2;
            end else if (state == RESP && grant) begin
                pend1 <= 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_d;
    end

    // Next state: IDLE -> MEM on any pending request, MEM -> RESP on completion, RESP -> IDLE
    always_comb begin
        state_d = state;
        if (start)               state_d = MEM;
        else if (done)           state_d = RESP;
        else if (state == RESP)  state_d = IDLE;
    end

    // Memory port and read-data registers, loaded from the winner and held through MEM
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            Data_in    <= '0;
            Data_in2   <= '0;
        end else begin
            if (start) begin
                mem_req   <= 1'b1;
                mem_addr  <= win ? addr1 : addr0;
                mem_wdata <= win ? wdata1 : wdata0;
                mem_we    <= win ? we1 : we0;
                grant     <= win;
            end else if (done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (!mem_we && grant)  Data_in2 <= rdata_eff;
                if (!mem_we && !grant) Data_in  <= rdata_eff;
            end
            if (state == RESP) last_grant <= grant;
        end
    end
endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb_dual_core_mem_arbiter: directed self-checking bench for dual_core_mem_arbiter.
module tb_dual_core_mem_arbiter;
    logic        Clock, nReset;
    logic [63:0] Sysbus, Sysbus2, Data_in, Data_in2, mem_wdata, mem_rdata;
    logic        nALE, nME, RnW, Ready, nALE2, nME2, RnW2, Ready2;
    logic [15:0] mem_addr;
    logic        mem_we, mem_req, mem_ack, grant;
    int          n_cmp = 0, n_err = 0;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err;
`endif

    dual_core_mem_arbiter #(.ADDR_W(16), .DATA_W(64), .TIMEOUT(4)) dut (
        .Clock(Clock), .nReset(nReset),
        .Sysbus(Sysbus), .nALE(nALE), .nME(nME), .RnW(RnW), .Data_in(Data_in), .Ready(Ready),
        .Sysbus2(Sysbus2), .nALE2(nALE2), .nME2(nME2), .RnW2(RnW2), .Data_in2(Data_in2), .Ready2(Ready2),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef MEM_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .grant(grant)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clock);
    endtask

    task automatic issue(input bit c0, input bit c1, input bit rnw, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
        if (c0) begin nALE = 1'b0; Sysbus = 64'(a0); end
        if (c1) begin nALE2 = 1'b0; Sysbus2 = 64'(a1); end
        cyc();
        nALE = 1'b1;
        nALE2 = 1'b1;
        if (c0) begin nME = 1'b0; RnW = rnw; Sysbus = d0; end
        if (c1) begin nME2 = 1'b0; RnW2 = rnw; Sysbus2 = d1; end
        cyc();
        nME = 1'b1;
        nME2 = 1'b1;
    endtask

    task automatic serve(input bit g, input bit we, input logic [15:0] a, input logic [63:0] wd,
                         input int lat, input logic [63:0] rd);
        int i = 0;
        while (!mem_req && i < 20) begin cyc(); i++; end
        check("req_seen", mem_req, 1);
        if (!mem_req) return;
        check("grant", grant, g);
        check("mem_we", mem_we, we);
        check("mem_addr", mem_addr, a);
        if (we) check("mem_wdata", mem_wdata, wd);
        for (int j = 1; j < lat; j++) begin
            cyc();
            check("hold_req", mem_req, 1);
            check("hold_addr", mem_addr, a);
            check("hold_we", mem_we, we);
            if (we) check("hold_wdata", mem_wdata, wd);
            check("hold_noready", {Ready, Ready2}, 0);
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        cyc();
        mem_ack = 1'b0;
        mem_rdata = '0;
        check("ready", {Ready, Ready2}, g ? 2'b01 : 2'b10);
        check("req_drop", mem_req, 0);
        if (!we) check("rdata", g ? Data_in2 : Data_in, rd);
        cyc();
        check("ready_end", {Ready, Ready2}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nReset = 1'b0;
        {nALE, nME, nALE2, nME2, RnW, RnW2} = 6'b111111;
        Sysbus = '0; Sysbus2 = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) cyc();
        check("rst_data_in", Data_in, 0);
        check("rst_ready", {Ready, Ready2}, 0);
        check("rst_mem", {mem_req, mem_we, grant}, 0);
        check("rst_addr", mem_addr, 0);
        nReset = 1'b1;
        cyc();

        // core 0 read, single-cycle ack
        issue(1, 0, 1, 16'h0040, 16'h0, 64'h0, 64'h0);
        serve(0, 0, 16'h0040, 64'h0, 1, 64'hDEAD_BEEF_0123_4567);
        check("t1_data_in2", Data_in2, 0);

        // core 1 write, ack after three cycles
        issue(0, 1, 0, 16'h0, 16'h1234, 64'h0, 64'h55AA);
        serve(1, 1, 16'h1234, 64'h55AA, 3, 64'hFFFF);
        check("t2_data_in2", Data_in2, 0);
        check("t2_data_in", Data_in, 64'hDEAD_BEEF_0123_4567);

        // ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 64'hBAD;
        cyc();
        mem_ack = 1'b0; mem_rdata = '0;
        check("idle_ack_ready", {Ready, Ready2}, 0);
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_data", Data_in, 64'hDEAD_BEEF_0123_4567);

        // simultaneous requests alternate starting with core 0
        for (int r = 0; r < 3; r++) begin
            issue(1, 1, 1, 16'h0300 + 16'(r), 16'h0400 + 16'(r), 64'h0, 64'h0);
            serve(0, 0, 16'h0300 + 16'(r), 64'h0, 1, 64'h1000 + 64'(r));
            serve(1, 0, 16'h0400 + 16'(r), 64'h0, 2, 64'h2000 + 64'(r));
        end
        check("rr_data_in", Data_in, 64'h1002);
        check("rr_data_in2", Data_in2, 64'h2002);

        // asynchronous reset during MEM aborts without Ready
        issue(1, 0, 1, 16'h0080, 16'h0, 64'h0, 64'h0);
        for (int i = 0; i < 20 && !mem_req; i++) cyc();
        check("abort_req_up", mem_req, 1);
        nReset = 1'b0;
        #1;
        check("abort_req_drop", mem_req, 0);
        check("abort_ready", {Ready, Ready2}, 0);
        check("abort_data_in", Data_in, 0);
        cyc();
        nReset = 1'b1;
        repeat (2) begin
            cyc();
            check("abort_idle", {mem_req, Ready, Ready2}, 0);
        end
        issue(1, 0, 1, 16'h0100, 16'h0, 64'h0, 64'h0);
        serve(0, 0, 16'h0100, 64'h0, 1, 64'hCAFE);

        // nME held low yields one access; a high-low toggle yields exactly one more
        nALE = 1'b0; Sysbus = 64'h0200;
        cyc();
        nALE = 1'b1; nME = 1'b0; RnW = 1'b1;
        serve(0, 0, 16'h0200, 64'h0, 1, 64'hA5);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("held_low_idle", mem_req, 0);
        end
        nME = 1'b1;
        cyc();
        nME = 1'b0;
        serve(0, 0, 16'h0200, 64'h0, 1, 64'h5A);
        repeat (3) begin
            cyc();
            check("toggle_once", mem_req, 0);
        end
        nME = 1'b1;
        cyc();

`ifdef MEM_TIMEOUT_EN
        // no ack: abort after four MEM cycles with all-ones data
        issue(1, 0, 1, 16'h0500, 16'h0, 64'h0, 64'h0);
        for (int i = 0; i < 20 && !mem_req; i++) cyc();
        check("tmo_req", mem_req, 1);
        repeat (4) cyc();
        check("tmo_ready", {Ready, Ready2}, 2'b10);
        check("tmo_data", Data_in, '1);
        check("tmo_err", bus_err, 1);
        repeat (3) cyc();
        check("tmo_err_sticky", bus_err, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
